// File: rtl/spi_slave_sync_if.sv
// -----------------------------------------------------------------------------
// spi_slave_sync_if
// Bundles the raw SPI pins and the byte-level application handshake of the
// clock-domain SPI slave front end.
//   sclk, mosi, ce0 : raw SPI pins from the host (ce0 active low)
//   miso            : SPI data out, 0 when not selected
//   tx_data/tx_load : transmit byte and its "sampled" strobe
//   rx_data/rx_valid: last received byte and its update strobe
//   busy            : frame in progress
//   frame_done      : frame-end strobe
//   byte_count      : complete bytes in current/last frame (saturating)
// Modport slave is the front end's view; modport master is the host/app view.
// -----------------------------------------------------------------------------
interface spi_slave_sync_if;
   logic       sclk;
   logic       mosi;
   logic       ce0;
   logic       miso;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       frame_done;
   logic [7:0] byte_count;

   modport slave (
      input  sclk, mosi, ce0, tx_data,
      output miso, tx_load, rx_data, rx_valid, busy, frame_done, byte_count
   );

   modport master (
      output sclk, mosi, ce0, tx_data,
      input  miso, tx_load, rx_data, rx_valid, busy, frame_done, byte_count
   );
endinterface

// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
// SPI mode-0 slave front end running entirely in the board clock domain.
// Raw SCLK/MOSI/CE0 are oversampled through SYNC_STAGES flops; SCLK and CE0
// edges are found by comparing the last stage with a history flop. Received
// bytes (MSB first) are presented as rx_data with a one-cycle rx_valid, and
// transmit bytes are taken from tx_data (one-cycle tx_load) and shifted out
// on miso, which changes after falling SCLK edges.
// Ports:
//   clk  : board clock, rising edge
//   rst  : synchronous active-high reset
//   spi  : spi_slave_sync_if.slave (pins + application handshake)
// -----------------------------------------------------------------------------
module spi_slave_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   spi_slave_sync_if.slave spi
);

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_ACTIVE    = 2'd2
   } state_t;

   // After reset the synchronisers hold their reset values, not real pin
   // samples; WAIT_IDLE only trusts ce0 once the chain and history flop have
   // been refilled, otherwise a CE0 held low through reset would look idle.
   localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] ce0_sync_q,  ce0_sync_d;
   logic                   sclk_hist_q, sclk_hist_d;
   logic                   ce0_hist_q,  ce0_hist_d;

   state_t     state_q, state_d;
   logic [2:0] settle_q, settle_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] byte_cnt_q, byte_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_load_q, tx_load_d;
   logic       frame_done_q, frame_done_d;
   logic       busy_q, busy_d;
   logic       miso_q, miso_d;

   logic sclk_s, mosi_s, ce0_s;
   logic sclk_rise_s, sclk_fall_s, ce0_rise_s, ce0_fall_s;
   logic [7:0] rx_byte_s;

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign ce0_s       = ce0_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_hist_q;
   assign sclk_fall_s = ~sclk_s & sclk_hist_q;
   assign ce0_rise_s  = ce0_s & ~ce0_hist_q;
   assign ce0_fall_s  = ~ce0_s & ce0_hist_q;
   // MOSI goes through the same depth as SCLK, so the last stage lines up
   // with the sample in which the rising SCLK edge first appeared.
   assign rx_byte_s   = {rx_shift_q[6:0], mosi_s};

   // Synchroniser shift chains and edge-history inputs.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      ce0_sync_d  = {ce0_sync_q[SYNC_STAGES-2:0],  spi.ce0};
      sclk_hist_d = sclk_s;
      ce0_hist_d  = ce0_s;
   end

   // Frame FSM next state plus shift register, counter and strobe updates.
   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      rx_shift_d   = rx_shift_q;
      tx_shift_d   = tx_shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      tx_load_d    = 1'b0;
      frame_done_d = 1'b0;

      case (state_q)
         ST_WAIT_IDLE: begin
            if (settle_q != SETTLE_CYCLES) begin
               settle_d = settle_q + 3'd1;
            end else if (ce0_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_IDLE: begin
            if (ce0_fall_s) begin
               state_d    = ST_ACTIVE;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 8'd0;
               rx_shift_d = 8'd0;
               tx_shift_d = spi.tx_data;
               tx_load_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            // A CE0 edge takes priority; an SCLK edge in the same cycle is lost.
            if (ce0_rise_s) begin
               state_d      = ST_IDLE;
               bit_cnt_d    = 3'd0;
               frame_done_d = 1'b1;
            end else if (sclk_rise_s) begin
               rx_shift_d = rx_byte_s;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = rx_byte_s;
                  rx_valid_d = 1'b1;
                  if (byte_cnt_q != 8'd255) begin
                     byte_cnt_d = byte_cnt_q + 8'd1;
                  end else begin
                     byte_cnt_d = byte_cnt_q;
                  end
               end else begin
                  rx_data_d = rx_data_q;
               end
            end else if (sclk_fall_s) begin
               // Counter at 0 on a falling edge means a byte just finished.
               if (bit_cnt_q == 3'd0) begin
                  tx_shift_d = spi.tx_data;
                  tx_load_d  = 1'b1;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         default: begin
            state_d = ST_WAIT_IDLE;
         end
      endcase

      busy_d = (state_d == ST_ACTIVE);
      miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[7] : 1'b0;
   end

   // All state, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q  <= {SYNC_STAGES{1'b0}};
         mosi_sync_q  <= {SYNC_STAGES{1'b0}};
         ce0_sync_q   <= {SYNC_STAGES{1'b1}};
         sclk_hist_q  <= 1'b0;
         ce0_hist_q   <= 1'b1;
         state_q      <= ST_WAIT_IDLE;
         settle_q     <= 3'd0;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= 8'd0;
         rx_shift_q   <= 8'd0;
         tx_shift_q   <= 8'd0;
         rx_data_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         tx_load_q    <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         miso_q       <= 1'b0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         ce0_sync_q   <= ce0_sync_d;
         sclk_hist_q  <= sclk_hist_d;
         ce0_hist_q   <= ce0_hist_d;
         state_q      <= state_d;
         settle_q     <= settle_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         rx_shift_q   <= rx_shift_d;
         tx_shift_q   <= tx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         tx_load_q    <= tx_load_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         miso_q       <= miso_d;
      end
   end

   assign spi.miso       = miso_q;
   assign spi.tx_load    = tx_load_q;
   assign spi.rx_data    = rx_data_q;
   assign spi.rx_valid   = rx_valid_q;
   assign spi.busy       = busy_q;
   assign spi.frame_done = frame_done_q;
   assign spi.byte_count = byte_cnt_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sync
// Drives spi_slave_sync as an SPI mode-0 master plus a byte-level application.
// Expected values come from byte queues: what the master sent must come back
// on rx_data, and the tx bytes handed over on each tx_load must appear on miso.
// -----------------------------------------------------------------------------
module tb_spi_slave_sync;

   logic clk;
   logic rst;

   spi_slave_sync_if spi_bus ();

   spi_slave_sync #(.SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .spi (spi_bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks;
   int n_fail;
   int n_rx_valid;
   int n_tx_load;
   int n_frame_done;
   logic busy_seen;
   logic busy_mid;

   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] send_b[$];
   logic [7:0] exp_tx[$];
   logic [7:0] miso_got[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; the application side reacts to strobes seen after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (spi_bus.tx_load === 1'b1) begin
         n_tx_load++;
         if (tx_q.size() > 0) spi_bus.tx_data = tx_q.pop_front();
      end
      if (spi_bus.rx_valid === 1'b1) begin
         n_rx_valid++;
         rx_q.push_back(spi_bus.rx_data);
      end
      if (spi_bus.frame_done === 1'b1) n_frame_done++;
      if (spi_bus.busy === 1'b1) busy_seen = 1'b1;
   endtask

   task automatic clear_stats();
      n_rx_valid   = 0;
      n_tx_load    = 0;
      n_frame_done = 0;
      busy_seen    = 1'b0;
      busy_mid     = 1'b0;
      rx_q.delete();
      miso_got.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},       {31'd0, spi_bus.miso},       32'd0);
      check({tag, "_rx_data"},    {24'd0, spi_bus.rx_data},    32'd0);
      check({tag, "_rx_valid"},   {31'd0, spi_bus.rx_valid},   32'd0);
      check({tag, "_tx_load"},    {31'd0, spi_bus.tx_load},    32'd0);
      check({tag, "_busy"},       {31'd0, spi_bus.busy},       32'd0);
      check({tag, "_frame_done"}, {31'd0, spi_bus.frame_done}, 32'd0);
      check({tag, "_byte_count"}, {24'd0, spi_bus.byte_count}, 32'd0);
   endtask

   // Master: send nbits of b MSB first; miso is read at the end of SCLK high.
   task automatic send_bits(input logic [7:0] b, input int nbits, input int half,
                            output logic [7:0] mb);
      mb = 8'd0;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_bus.mosi = b[i];
         repeat (half) tick();
         spi_bus.sclk = 1'b1;
         repeat (half) tick();
         mb[i] = spi_bus.miso;
         spi_bus.sclk = 1'b0;
      end
   endtask

   task automatic run_frame(input int nbytes, input int tail_bits, input int half);
      logic [7:0] mb;
      spi_bus.ce0 = 1'b0;
      repeat (6) tick();
      for (int i = 0; i < nbytes; i++) begin
         send_bits(send_b[i], 8, half, mb);
         miso_got.push_back(mb);
      end
      if (tail_bits > 0) send_bits(send_b[nbytes], tail_bits, half, mb);
      busy_mid = spi_bus.busy;
      repeat (6) tick();
      spi_bus.ce0 = 1'b1;
      repeat (8) tick();
   endtask

   // Full-byte frame of send_b, with exp_tx presented one byte per tx_load.
   task automatic frame_check(input string tag, input int half);
      int nbytes;
      nbytes = send_b.size();
      spi_bus.tx_data = exp_tx[0];
      tx_q.delete();
      for (int i = 1; i < exp_tx.size(); i++) tx_q.push_back(exp_tx[i]);
      clear_stats();
      run_frame(nbytes, 0, half);
      check({tag, "_rx_valid_cnt"}, n_rx_valid, nbytes);
      for (int i = 0; i < nbytes; i++) begin
         check($sformatf("%s_rx%0d", tag, i),
               (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, send_b[i]});
         check($sformatf("%s_miso%0d", tag, i), {24'd0, miso_got[i]}, {24'd0, exp_tx[i]});
      end
      check({tag, "_frame_done_cnt"}, n_frame_done, 1);
      check({tag, "_tx_load_cnt"}, n_tx_load, nbytes + 1);
      check({tag, "_byte_count"}, {24'd0, spi_bus.byte_count},
            (nbytes > 255) ? 32'd255 : nbytes);
      check({tag, "_busy_mid"}, {31'd0, busy_mid}, 32'd1);
      check({tag, "_busy_end"}, {31'd0, spi_bus.busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] mb;
      int nb;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      spi_bus.sclk    = 1'b0;
      spi_bus.mosi    = 1'b0;
      spi_bus.ce0     = 1'b0;
      spi_bus.tx_data = 8'h00;
      clear_stats();

      // Reset held with CE0 low, then clock a byte without a CE0 edge.
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      clear_stats();
      send_bits(8'hA5, 8, 4, mb);
      repeat (6) tick();
      check("ce0_low_rx_valid", n_rx_valid, 0);
      check("ce0_low_busy", {31'd0, busy_seen}, 32'd0);
      spi_bus.ce0 = 1'b1;
      repeat (8) tick();
      send_b = '{8'hA5};
      exp_tx = '{8'h00};
      frame_check("first_a5", 4);

      // MISO pattern at the fastest allowed SCLK.
      send_b = '{8'hFF};
      exp_tx = '{8'h3C};
      frame_check("tx_3c", 3);

      // Three-byte frame with tx_data refreshed after each tx_load.
      send_b = '{8'h01, 8'h80, 8'h7E};
      exp_tx = '{8'h11, 8'h22, 8'h33};
      frame_check("three_byte", 4);

      // Partial byte is discarded at frame end.
      send_b = '{8'($urandom)};
      clear_stats();
      run_frame(0, 5, 4);
      check("partial_rx_valid", n_rx_valid, 0);
      check("partial_rx_data", {24'd0, spi_bus.rx_data}, 32'h7E);
      check("partial_frame_done", n_frame_done, 1);
      check("partial_byte_count", {24'd0, spi_bus.byte_count}, 32'd0);
      send_b = '{8'($urandom)};
      exp_tx = '{8'($urandom)};
      frame_check("after_partial", 4);

      // Reset in the middle of 0xC3, with CE0 still low afterwards.
      clear_stats();
      spi_bus.ce0 = 1'b0;
      repeat (6) tick();
      send_bits(8'hC3, 4, 4, mb);
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      clear_stats();
      send_bits(8'h3C, 4, 4, mb);
      send_bits(8'h5A, 8, 4, mb);
      repeat (6) tick();
      check("post_reset_rx_valid", n_rx_valid, 0);
      check("post_reset_busy", {31'd0, busy_seen}, 32'd0);
      check("post_reset_tx_load", n_tx_load, 0);
      spi_bus.ce0 = 1'b1;
      repeat (8) tick();
      send_b = '{8'($urandom)};
      exp_tx = '{8'($urandom)};
      frame_check("after_reset", 4);

      // Long frame: byte_count saturates, rx_valid keeps pulsing.
      send_b.delete();
      exp_tx.delete();
      for (int i = 0; i < 260; i++) begin
         send_b.push_back(8'($urandom));
         exp_tx.push_back(8'($urandom));
      end
      frame_check("long", 3);

      // Random short frames at random legal SCLK rates.
      for (int f = 0; f < 3; f++) begin
         nb = $urandom_range(1, 4);
         send_b.delete();
         exp_tx.delete();
         for (int i = 0; i < nb; i++) begin
            send_b.push_back(8'($urandom));
            exp_tx.push_back(8'($urandom));
         end
         frame_check($sformatf("rand%0d", f), $urandom_range(3, 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
